// File: rtl/dff_response_checker.sv
// dff_response_checker: golden-model checker for a sync-reset D flip-flop
module dff_response_checker #(
  parameter int CNT_W = 8,
  parameter int SETTLE = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             dut_reset,
  input  logic             dut_d,
  input  logic             dut_q,
  output logic             expected_q,
  output logic             mismatch,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [15:0]      checked_count,
  output logic [15:0]      first_fail_cycle,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE, WAIT_RST, CHECK, HALT} state_t;
  state_t st;
  logic [3:0] settle;
  logic [15:0] cycle_count;
  logic seen, live, cmp, bad;
  assign state = st;
  always_comb begin
    live = st == WAIT_RST || st == CHECK;
    cmp = st == CHECK && enable && !clear;
    bad = cmp && (dut_q !== expected_q);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= IDLE;
      expected_q <= 1'b0;
      mismatch <= 1'b0;
      error <= 1'b0;
      err_count <= '0;
      checked_count <= '0;
      first_fail_cycle <= '0;
      settle <= '0;
      cycle_count <= '0;
      seen <= 1'b0;
    end else begin
      mismatch <= bad;
      if (live) expected_q <= dut_reset ? 1'b0 : dut_d;
      if (st == CHECK) cycle_count <= cycle_count + 16'd1;
      if (cmp) checked_count <= checked_count + 16'd1;
      if (bad) begin
        err_count <= &err_count ? err_count : err_count + 1'b1;
        error <= 1'b1;
        if (!error) first_fail_cycle <= cycle_count;
      end
      if (clear) begin
        error <= 1'b0;
        err_count <= '0;
        checked_count <= '0;
        first_fail_cycle <= '0;
        mismatch <= 1'b0;
        seen <= 1'b0;
        st <= enable ? WAIT_RST : IDLE;
      end else if (!enable) st <= IDLE;
      else
        case (st)
          IDLE: begin
            seen <= 1'b0;
            st <= WAIT_RST;
          end
          WAIT_RST:
            if (dut_reset) begin
              seen <= 1'b1;
              settle <= 4'(SETTLE);
            end else if (seen) begin
              if (settle <= 4'd1) begin
                st <= CHECK;
                cycle_count <= '0;
              end else settle <= settle - 4'd1;
            end
          CHECK: if (bad && STOP_ON_FAIL) st <= HALT;
          HALT: st <= HALT;
        endcase
    end
endmodule
